// File: rtl/fadc_pkg.sv
// Shared types and helpers for the flash-ADC encoder back end.
package fadc_pkg;

  typedef enum logic [1:0] {
    FADC_RAW  = 2'd0,
    FADC_CORR = 2'd1,
    FADC_AVG  = 2'd2,
    FADC_RSVD = 2'd3
  } fadc_mode_e;

  localparam int unsigned BUBBLE_CNT_W = 8;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned fadc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fadc_therm2bin.sv
// Majority bubble correction of a thermometer word followed by popcount.
module fadc_therm2bin
  import fadc_pkg::*;
#(
  parameter  int unsigned NCOMP = 255,
  localparam int unsigned OUT_W = fadc_clog2(NCOMP + 1)
) (
  input  logic [NCOMP-1:0] therm,
  input  logic             bypass,
  output logic [OUT_W-1:0] bin,
  output logic             bubble
);

  logic [NCOMP+1:0] ext;
  logic [NCOMP-1:0] corr;
  logic [NCOMP-1:0] sel;

  // 3-input majority per bit, with an implied 1 below bit 0 and 0 above the top bit.
  always_comb begin
    ext  = {1'b0, therm, 1'b1};
    corr = '0;
    for (int unsigned i = 0; i < NCOMP; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    bubble = (corr != therm);
    sel    = bypass ? therm : corr;
  end

  // Population count of the selected word gives the binary code.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < NCOMP; i++) begin
      bin = bin + OUT_W'(sel[i]);
    end
  end

endmodule

// File: rtl/fadc_enc.sv
// Flash-ADC back end: capture, bubble correction, encode, optional box-car
// averaging, valid/ready output with bubble statistics and overrun flag.
module fadc_enc
  import fadc_pkg::*;
#(
  parameter  int unsigned NCOMP   = 255,
  parameter  int unsigned AVG_MAX = 4,
  localparam int unsigned OUT_W   = fadc_clog2(NCOMP + 1),
  localparam int unsigned K_W     = fadc_clog2(AVG_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NCOMP-1:0]        therm_in,
  input  logic [1:0]              mode,
  input  logic [K_W-1:0]          avg_log2,
  input  logic                    clear_flags,
  output logic [OUT_W-1:0]        code_out,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt,
  output logic                    overrun
);

  localparam int unsigned ACC_W = OUT_W + AVG_MAX;
  localparam int unsigned CNT_W = AVG_MAX;

  logic [NCOMP-1:0]        t1_q, t1_d, t2_q, t2_d;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [OUT_W-1:0]        code3_q, code3_d;
  logic [1:0]              mode_q, mode_d;
  logic [K_W-1:0]          avg_q, avg_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    valid_q, valid_d;
  logic [BUBBLE_CNT_W-1:0] bcnt_q, bcnt_d;
  logic                    ovr_q, ovr_d;

  fadc_mode_e              mode_sel;
  logic [OUT_W-1:0]        s2_bin;
  logic                    s2_bubble;
  logic [K_W-1:0]          k_eff;
  logic                    avg_on;
  logic                    flush;
  logic [ACC_W-1:0]        acc_base, sum;
  logic [CNT_W-1:0]        cnt_base, last_cnt;
  logic                    res_vld;
  logic [OUT_W-1:0]        res;

  assign mode_sel = fadc_mode_e'(mode);

  fadc_therm2bin #(
    .NCOMP (NCOMP)
  ) u_therm2bin (
    .therm  (t2_q),
    .bypass (mode_sel == FADC_RAW),
    .bin    (s2_bin),
    .bubble (s2_bubble)
  );

  // Three-stage sample pipeline; dropping enable kills every in-flight sample.
  always_comb begin
    t1_d    = enable ? therm_in : t1_q;
    v1_d    = enable;
    t2_d    = t1_q;
    v2_d    = v1_q & enable;
    code3_d = s2_bin;
    v3_d    = v2_q & enable;
    mode_d  = mode;
    avg_d   = avg_log2;
  end

  // Box-car averager; a mode/exponent change restarts it with the current sample as first.
  always_comb begin
    k_eff    = (32'(avg_log2) > AVG_MAX) ? K_W'(AVG_MAX) : avg_log2;
    avg_on   = (mode_sel == FADC_AVG) && (k_eff != '0);
    flush    = !enable || (mode != mode_q) || (avg_log2 != avg_q);
    acc_base = flush ? '0 : acc_q;
    cnt_base = flush ? '0 : cnt_q;
    sum      = acc_base + ACC_W'(code3_q);
    last_cnt = CNT_W'((32'd1 << k_eff) - 32'd1);
    res_vld  = 1'b0;
    res      = code3_q;
    acc_d    = '0;
    cnt_d    = '0;
    if (v3_q && enable) begin
      if (avg_on) begin
        if (cnt_base == last_cnt) begin
          res_vld = 1'b1;
          res     = OUT_W'(sum >> k_eff);
        end else begin
          acc_d = sum;
          cnt_d = cnt_base + CNT_W'(1);
        end
      end else begin
        res_vld = 1'b1;
      end
    end else if (avg_on) begin
      acc_d = acc_base;
      cnt_d = cnt_base;
    end
  end

  // Output holding register, overrun on a drop, saturating bubble counter; clear wins.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    bcnt_d  = bcnt_q;
    if (res_vld) begin
      if (!valid_q || code_ready) begin
        out_d   = res;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && code_ready) begin
      valid_d = 1'b0;
    end
    if (v2_q && s2_bubble && (bcnt_q != '1)) begin
      bcnt_d = bcnt_q + BUBBLE_CNT_W'(1);
    end
    if (clear_flags) begin
      bcnt_d = '0;
      ovr_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t1_q    <= '0;
      t2_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      code3_q <= '0;
      mode_q  <= '0;
      avg_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      bcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      code3_q <= code3_d;
      mode_q  <= mode_d;
      avg_q   <= avg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      bcnt_q  <= bcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign code_out   = out_q;
  assign code_valid = valid_q;
  assign bubble_cnt = bcnt_q;
  assign overrun    = ovr_q;

endmodule
